// File: rtl/nec_prefetch.sv
// Instruction prefetch controller: keeps an 8-byte queue ahead of the decoder
// by issuing 16-bit word fetches over a req/ack handshake, with flush on set_pc.
module nec_prefetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_1,
    input  logic        ce_2,
    input  logic [15:0] cs,
    input  logic [15:0] dec_pc,
    input  logic [15:0] new_pc,
    input  logic        set_pc,
    input  logic        suspend,
    output logic        pf_req,
    output logic [19:0] pf_addr,
    input  logic        pf_ack,
    input  logic [15:0] pf_data,
    output logic [63:0] ipq,
    output logic [3:0]  ipq_len
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [15:0] fetch_ip_r;
    logic [15:0] fetch_ip_s;
    logic [15:0] fetch_ip_adv_s;
    logic        req_s;
    logic [19:0] addr_s;
    logic [3:0]  len_s;
    logic        wr_en_s;
    logic        en_s;
    logic [2:0]  slot_s;
    logic [2:0]  slot_hi_s;
    logic [7:0]  ipq_r [8];

    // Segment:offset to a word-aligned 20-bit physical address (wraps at 1 MiB).
    function automatic logic [19:0] phys_addr(input logic [15:0] seg, input logic [15:0] off);
        return {seg, 4'b0000} + {4'b0000, off & 16'hFFFE};
    endfunction

    // Room for another fetch: two free bytes for a full word, one for an odd start.
    function automatic logic fetch_needed(input logic [15:0] fip, input logic [15:0] dpc);
        logic [15:0] used;
        used = fip - dpc;
        if (fip[0]) begin
            return (used <= 16'd7);
        end else begin
            return (used <= 16'd6);
        end
    endfunction

    assign en_s      = ce_1 | ce_2;
    assign slot_s    = fetch_ip_r[2:0];
    assign slot_hi_s = slot_s + 3'd1;

    // Next-state, next fetch pointer and request outputs.
    always_comb begin
        state_s        = state_r;
        fetch_ip_s     = fetch_ip_r;
        req_s          = pf_req;
        addr_s         = pf_addr;
        wr_en_s        = 1'b0;
        fetch_ip_adv_s = fetch_ip_r + (fetch_ip_r[0] ? 16'd1 : 16'd2);
        case (state_r)
            ST_IDLE: begin
                if (set_pc) begin
                    fetch_ip_s = new_pc;
                    state_s    = ST_IDLE;
                    req_s      = 1'b0;
                end else if (!suspend && fetch_needed(fetch_ip_r, dec_pc)) begin
                    state_s = ST_REQ;
                    req_s   = 1'b1;
                    addr_s  = phys_addr(cs, fetch_ip_r);
                end else begin
                    state_s = ST_IDLE;
                    req_s   = 1'b0;
                end
            end
            ST_REQ: begin
                if (set_pc) begin
                    fetch_ip_s = new_pc;
                    if (pf_ack) begin
                        state_s = ST_IDLE;
                        req_s   = 1'b0;
                    end else begin
                        // The bus cycle cannot be aborted; wait it out and drop the data.
                        state_s = ST_DISCARD;
                        req_s   = 1'b1;
                    end
                end else if (pf_ack) begin
                    wr_en_s    = 1'b1;
                    fetch_ip_s = fetch_ip_adv_s;
                    if (!suspend && fetch_needed(fetch_ip_adv_s, dec_pc)) begin
                        state_s = ST_REQ;
                        req_s   = 1'b1;
                        addr_s  = phys_addr(cs, fetch_ip_adv_s);
                    end else begin
                        state_s = ST_IDLE;
                        req_s   = 1'b0;
                    end
                end else begin
                    state_s = ST_REQ;
                    req_s   = 1'b1;
                end
            end
            ST_DISCARD: begin
                if (set_pc) begin
                    fetch_ip_s = new_pc;
                end else begin
                    fetch_ip_s = fetch_ip_r;
                end
                if (pf_ack) begin
                    state_s = ST_IDLE;
                    req_s   = 1'b0;
                end else begin
                    state_s = ST_DISCARD;
                    req_s   = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                req_s   = 1'b0;
            end
        endcase
        // Difference is bounded to 0..8 by the decoder, so the low nibble suffices.
        len_s = fetch_ip_s[3:0] - dec_pc[3:0];
    end

    // State, fetch pointer and handshake registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            fetch_ip_r <= 16'h0000;
            pf_req     <= 1'b0;
            pf_addr    <= 20'h00000;
            ipq_len    <= 4'd0;
        end else if (en_s) begin
            state_r    <= state_s;
            fetch_ip_r <= fetch_ip_s;
            pf_req     <= req_s;
            pf_addr    <= addr_s;
            ipq_len    <= len_s;
        end
    end

    // Queue byte storage, written little-endian at the current fetch slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                ipq_r[i] <= 8'h00;
            end
        end else if (en_s && wr_en_s) begin
            if (fetch_ip_r[0]) begin
                ipq_r[slot_s] <= pf_data[15:8];
            end else begin
                ipq_r[slot_s]    <= pf_data[7:0];
                ipq_r[slot_hi_s] <= pf_data[15:8];
            end
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_pack
        assign ipq[8*g +: 8] = ipq_r[g];
    end

endmodule
